// File: rtl/spi_pkg.sv
// Shared constants, frame layout and FSM state type for the SPI weight-frame controller.
package spi_pkg;

  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 20;
  localparam int CNT_W      = 5;
  localparam int FCNT_W     = 8;
  localparam int FRAME_BITS = 32;

  localparam logic [ADDR_W-1:0] DEF_ADDR_MIN  = 7'h01;
  localparam logic [ADDR_W-1:0] DEF_ADDR_MAX  = 7'h08;
  localparam logic [ADDR_W-1:0] DEF_ADDR_CTRL = 7'h7F;

  // Frame layout, MSB first: [31] R/W, [30:24] address, [23:4] data, [3:0] unused
  localparam int RW_POS  = 31;
  localparam int ADDR_HI = 30;
  localparam int ADDR_LO = 24;
  localparam int DATA_HI = 23;
  localparam int DATA_LO = 4;

  // The receive register only needs to hold bits down to DATA_LO; the newest bit comes straight from MOSI.
  localparam int RX_W = DATA_HI;

  localparam logic [CNT_W-1:0] HDR_LAST_CNT = CNT_W'(FRAME_BITS - ADDR_LO - 1);
  localparam logic [CNT_W-1:0] RD_ADDR_CNT  = CNT_W'(FRAME_BITS - ADDR_LO);
  localparam logic [CNT_W-1:0] RD_LOAD_CNT  = CNT_W'(FRAME_BITS - ADDR_LO + 1);
  localparam logic [CNT_W-1:0] LAST_CNT     = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    WDATA,
    RDATA,
    CMPL
  } state_t;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                         input logic [ADDR_W-1:0] lo,
                                         input logic [ADDR_W-1:0] hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Width-parameterised shift register with parallel load, serial in at bit 0, MSB-first out.
module spi_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             SCLK,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sin,
  output logic [WIDTH-1:0] q
);

  // Load wins over shift so a transmit word can be captured on a shifting edge.
  always_ff @(posedge SCLK or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= load_val;
    end else if (shift) begin
      q <= {q[WIDTH-2:0], sin};
    end
  end

endmodule

// File: rtl/spi_frame_ctrl.sv
// SPI slave frame controller: decodes 32-bit frames into weight-bank writes, read-backs and status/clear.
module spi_frame_ctrl
  import spi_pkg::*;
#(
  parameter logic [6:0] ADDR_MIN  = DEF_ADDR_MIN,
  parameter logic [6:0] ADDR_MAX  = DEF_ADDR_MAX,
  parameter logic [6:0] ADDR_CTRL = DEF_ADDR_CTRL
) (
  input  logic        SCLK,
  input  logic        reset,
  input  logic        ss,
  input  logic        MOSI,
  output logic        MISO,
  output logic        wr_en,
  output logic [6:0]  wr_addr,
  output logic [19:0] wr_data,
  output logic [6:0]  rd_addr,
  input  logic [19:0] rd_data,
  output logic [7:0]  frame_cnt,
  output logic [1:0]  err
);

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic               hdr_rw;
  logic [ADDR_W-1:0]  hdr_addr;
  logic [RX_W-1:0]    rx_q;
  logic [DATA_W-1:0]  tx_q;
  logic [DATA_W-1:0]  tx_load_val;
  logic               rx_shift;
  logic               tx_load;
  logic               tx_shift;
  logic               in_frame;
  logic               abort;
  logic               hdr_valid;
  logic               hdr_is_ctrl;
  logic               tx_unused;

  assign in_frame    = state inside {HDR, WDATA, RDATA};
  assign abort       = in_frame && ss;
  assign hdr_valid   = addr_in_range(hdr_addr, ADDR_MIN, ADDR_MAX);
  assign hdr_is_ctrl = (hdr_addr == ADDR_CTRL);

  assign rx_shift    = ~ss;
  assign tx_shift    = (state == RDATA) && !ss;
  assign tx_load     = abort || ((state == RDATA) && !ss && (bit_cnt == RD_LOAD_CNT));
  assign tx_load_val = abort       ? '0 :
                       hdr_is_ctrl ? {frame_cnt, 10'b0, err} :
                                     rd_data;

  spi_shift_reg #(.WIDTH(RX_W)) u_rx (
    .SCLK     (SCLK),
    .reset    (reset),
    .load     (1'b0),
    .shift    (rx_shift),
    .load_val ('0),
    .sin      (MOSI),
    .q        (rx_q)
  );

  // Only the transmit MSB leaves the block; it empties to zero before the frame ends.
  spi_shift_reg #(.WIDTH(DATA_W)) u_tx (
    .SCLK     (SCLK),
    .reset    (reset),
    .load     (tx_load),
    .shift    (tx_shift),
    .load_val (tx_load_val),
    .sin      (1'b0),
    .q        (tx_q)
  );

  assign MISO      = tx_q[DATA_W-1];
  assign tx_unused = ^tx_q[DATA_W-2:0];

  // CMPL behaves like IDLE for a new frame, so a held-low ss starts the next header immediately.
  always_ff @(posedge SCLK or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      hdr_rw    <= 1'b0;
      hdr_addr  <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rd_addr   <= '0;
      frame_cnt <= '0;
      err       <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, CMPL: begin
          if (!ss) begin
            state   <= HDR;
            bit_cnt <= CNT_W'(1);
          end else begin
            state   <= IDLE;
            bit_cnt <= '0;
          end
        end
        HDR, WDATA, RDATA: begin
          if (ss) begin
            state   <= IDLE;
            bit_cnt <= '0;
            err[1]  <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
            if ((state == HDR) && (bit_cnt == HDR_LAST_CNT)) begin
              hdr_rw   <= rx_q[ADDR_W-1];
              hdr_addr <= {rx_q[ADDR_W-2:0], MOSI};
              state    <= rx_q[ADDR_W-1] ? WDATA : RDATA;
            end
            if ((state == RDATA) && (bit_cnt == RD_ADDR_CNT)) begin
              rd_addr <= hdr_addr;
            end
            // A clear is decided in its own branch, so it always overrides any error update.
            if ((state != HDR) && (bit_cnt == LAST_CNT)) begin
              state <= CMPL;
              if (hdr_is_ctrl) begin
                if (hdr_rw) begin
                  frame_cnt <= '0;
                  err       <= '0;
                end
              end else if (hdr_valid) begin
                frame_cnt <= frame_cnt + FCNT_W'(1);
                if (hdr_rw) begin
                  wr_en   <= 1'b1;
                  wr_addr <= hdr_addr;
                  wr_data <= rx_q[DATA_HI-1:DATA_LO-1];
                end
              end else begin
                err[0] <= 1'b1;
              end
            end
          end
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Self-checking bench for spi_frame_ctrl: directed scenarios plus randomized frames against a transaction-level model.
module tb_spi_frame_ctrl;

  logic        SCLK;
  logic        reset;
  logic        ss;
  logic        MOSI;
  logic        MISO;
  logic        wr_en;
  logic [6:0]  wr_addr;
  logic [19:0] wr_data;
  logic [6:0]  rd_addr;
  logic [19:0] rd_data;
  logic [7:0]  frame_cnt;
  logic [1:0]  err;

  logic [19:0] bank [128];
  int          total_checks = 0;
  int          bad_checks   = 0;
  int          pulse_seen   = 0;
  int          pulse_exp    = 0;
  logic [7:0]  m_cnt;
  logic [1:0]  m_err;

  spi_frame_ctrl dut (
    .SCLK      (SCLK),
    .reset     (reset),
    .ss        (ss),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .frame_cnt (frame_cnt),
    .err       (err)
  );

  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  // Weight bank stand-in: contents are owned by the model, returned immediately for any rd_addr.
  always_comb rd_data = bank[rd_addr];

  always @(negedge SCLK) if (wr_en) pulse_seen++;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_checks++;
    if (obs !== exp) begin
      bad_checks++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_miso"},    32'(MISO),      32'd0);
    checkOutput({tag, "_wr_en"},   32'(wr_en),     32'd0);
    checkOutput({tag, "_wr_addr"}, 32'(wr_addr),   32'd0);
    checkOutput({tag, "_wr_data"}, 32'(wr_data),   32'd0);
    checkOutput({tag, "_rd_addr"}, 32'(rd_addr),   32'd0);
    checkOutput({tag, "_cnt"},     32'(frame_cnt), 32'd0);
    checkOutput({tag, "_err"},     32'(err),       32'd0);
  endtask

  task automatic idle(input int n);
    ss   = 1'b1;
    MOSI = 1'($urandom);
    repeat (n) begin
      @(posedge SCLK);
      #1;
    end
  endtask

  // Drives nbits of a frame; records MISO and wr_en seen just after each edge, bit 31 first.
  task automatic drive_frame(input logic [31:0] frame, input int nbits,
                             output logic [31:0] mv, output logic [31:0] wv);
    mv = '0;
    wv = '0;
    for (int i = 0; i < nbits; i++) begin
      ss   = 1'b0;
      MOSI = frame[31-i];
      @(posedge SCLK);
      #1;
      mv[31-i] = MISO;
      wv[31-i] = wr_en;
    end
  endtask

  task automatic applyStimulus(input logic rw, input logic [6:0] addr,
                               input logic [19:0] data, input int nbits);
    logic [31:0] frame, mv, wv, exp_miso, exp_wr;
    logic [7:0]  pre_cnt;
    logic [1:0]  pre_err;
    frame   = {rw, addr, data, 4'($urandom_range(0, 15))};
    pre_cnt = m_cnt;
    pre_err = m_err;
    drive_frame(frame, nbits, mv, wv);
    if (nbits < 32) begin
      idle(1);
      m_err[1] = 1'b1;
      checkOutput("abort_wr",   wv, 32'd0);
      checkOutput("abort_miso", 32'(MISO), 32'd0);
      checkOutput("abort_err",  32'(err), 32'(m_err));
      checkOutput("abort_cnt",  32'(frame_cnt), 32'(m_cnt));
    end else begin
      exp_miso = '0;
      exp_wr   = '0;
      if (addr == 7'h7F) begin
        if (rw) begin
          m_cnt = '0;
          m_err = '0;
        end else begin
          exp_miso = {9'b0, pre_cnt, 10'b0, pre_err, 3'b0};
        end
      end else if (addr >= 7'h01 && addr <= 7'h08) begin
        m_cnt = m_cnt + 8'd1;
        if (rw) begin
          exp_wr     = 32'd1;
          bank[addr] = data;
          pulse_exp++;
        end else begin
          exp_miso = {9'b0, bank[addr], 3'b0};
        end
      end else begin
        m_err[0] = 1'b1;
      end
      checkOutput("miso_bits", mv, exp_miso);
      checkOutput("wr_strobe", wv, exp_wr);
      if (exp_wr != 0) begin
        checkOutput("wr_addr", 32'(wr_addr), 32'(addr));
        checkOutput("wr_data", 32'(wr_data), 32'(data));
      end
      checkOutput("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
      checkOutput("err",       32'(err),       32'(m_err));
    end
  endtask

  initial begin
    logic [31:0] mv, wv;
    for (int i = 0; i < 128; i++) bank[i] = 20'($urandom);
    m_cnt = '0;
    m_err = '0;
    reset = 1'b1;
    ss    = 1'b1;
    MOSI  = 1'b0;
    repeat (3) @(posedge SCLK);
    #1;
    checkResetState("por");
    reset = 1'b0;
    idle(2);

    applyStimulus(1'b1, 7'h03, 20'h08864, 32);
    idle(2);
    bank[5] = 20'hABCDE;
    applyStimulus(1'b0, 7'h05, 20'h00000, 32);
    idle(2);
    applyStimulus(1'b1, 7'h09, 20'h12345, 32);
    idle(2);
    applyStimulus(1'b1, 7'h02, 20'h54321, 17);
    applyStimulus(1'b1, 7'h04, 20'h0F0F0, 32);
    idle(1);
    applyStimulus(1'b0, 7'h7F, 20'h00000, 32);
    applyStimulus(1'b1, 7'h7F, 20'h00000, 32);
    applyStimulus(1'b1, 7'h01, 20'hFFFFF, 32);
    applyStimulus(1'b1, 7'h08, 20'h13579, 32);
    applyStimulus(1'b0, 7'h01, 20'h00000, 32);
    idle(2);

    // Reset in the middle of a write frame
    drive_frame({1'b1, 7'h06, 20'hCAFE1, 4'h0}, 20, mv, wv);
    checkOutput("rst_mid_wr", wv, 32'd0);
    reset = 1'b1;
    #2;
    checkResetState("mid");
    ss = 1'b1;
    repeat (2) @(posedge SCLK);
    #1;
    reset = 1'b0;
    m_cnt = '0;
    m_err = '0;
    idle(2);

    applyStimulus(1'b1, 7'h0A, 20'h11111, 32);
    applyStimulus(1'b0, 7'h03, 20'h00000, 9);
    applyStimulus(1'b0, 7'h06, 20'h00000, 32);
    applyStimulus(1'b0, 7'h7F, 20'h00000, 32);
    applyStimulus(1'b1, 7'h7F, 20'h00000, 32);
    idle(2);

    // Enough back-to-back reads to wrap the frame counter
    for (int n = 0; n < 257; n++) applyStimulus(1'b0, 7'($urandom_range(1, 8)), 20'h0, 32);
    idle(2);

    for (int n = 0; n < 300; n++) begin
      int         kind;
      logic       rw;
      logic [6:0] addr;
      int         nbits;
      kind  = $urandom_range(0, 99);
      nbits = 32;
      if (kind < 45) begin
        rw = 1'b1; addr = 7'($urandom_range(1, 8));
      end else if (kind < 80) begin
        rw = 1'b0; addr = 7'($urandom_range(1, 8));
      end else if (kind < 88) begin
        rw = 1'b1; addr = ($urandom_range(0, 1) == 0) ? 7'h00 : 7'($urandom_range(9, 126));
      end else if (kind < 92) begin
        rw = 1'b0; addr = 7'h7F;
      end else if (kind < 94) begin
        rw = 1'b1; addr = 7'h7F;
      end else begin
        rw = 1'($urandom); addr = 7'($urandom_range(1, 8)); nbits = $urandom_range(1, 31);
      end
      applyStimulus(rw, addr, 20'($urandom), nbits);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end

    idle(3);
    checkOutput("pulse_total", 32'(pulse_seen), 32'(pulse_exp));
    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
